// File: rtl/icb_adder_core_pkg.sv
// Shared definitions for the ICB adder datapath and its register slave.
// Holds state encodings, default widths and the slave register offsets.
// The optional saturating mode is selected with the ADDER_SAT_EN macro in
// the top-level file.
package icb_adder_core_pkg;

  // Default operand width (matches the slave register width) and chunk width
  localparam int DATA_W_DEF  = 32;
  localparam int CHUNK_W_DEF = 8;

  // Register offsets of the ICB adder slave
  localparam logic [3:0] REG_AUGEND_OFS  = 4'h0;
  localparam logic [3:0] REG_ADDEND_OFS  = 4'h4;
  localparam logic [3:0] REG_CONTROL_OFS = 4'h8;
  localparam logic [3:0] REG_SUM_OFS     = 4'hC;

  // Datapath sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_e;

  // Width of a chunk index able to count n chunks (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icb_adder_core_chunk.sv
// icb_adder_chunk: combinational CHUNK_W-bit adder slice with carry in/out.
module icb_adder_chunk #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] s,
  output logic               cout
);

  logic [CHUNK_W:0] total_s;

  // Zero-extend by one bit so the carry lands in the top bit
  assign total_s   = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
  assign {cout, s} = total_s;

endmodule

// File: rtl/icb_adder_core.sv
// icb_adder_core: multi-cycle chunked adder behind the ICB adder slave.
// A rising edge on control captures the operands and adds them CHUNK_W bits
// per cycle, LSB chunk first, with a registered carry between chunks.
// Optional macro ADDER_SAT_EN: saturate sum to all ones on final carry.
module icb_adder_core
  import icb_adder_core_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] augend,
  input  logic [DATA_W-1:0] addend,
  input  logic              control,
  output logic [DATA_W-1:0] sum,
  output logic              carry_out,
  output logic              busy,
  output logic              done
);

  localparam int N     = DATA_W / CHUNK_W;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e              state_r;
  state_e              state_next_s;
  logic                control_q_r;
  logic [IDX_W-1:0]    idx_r;
  logic                carry_r;
  logic [DATA_W-1:0]   shadow_a_r;
  logic [DATA_W-1:0]   shadow_b_r;
  logic [DATA_W-1:0]   result_r;
  logic [DATA_W-1:0]   sum_r;
  logic                carry_out_r;
  logic                busy_r;
  logic                done_r;

  logic                start_s;
  logic                last_chunk_s;
  logic [CHUNK_W-1:0]  chunk_a_s;
  logic [CHUNK_W-1:0]  chunk_b_s;
  logic [CHUNK_W-1:0]  chunk_sum_s;
  logic                chunk_cout_s;
  logic [DATA_W-1:0]   full_result_s;
  logic [DATA_W-1:0]   sum_next_s;

  // Only an idle engine accepts a new request; edges while busy are dropped
  assign start_s      = control & ~control_q_r & (state_r == ST_IDLE);
  assign last_chunk_s = (idx_r == LAST_IDX);

  // Select the operand chunk addressed by the current index
  assign chunk_a_s = shadow_a_r[int'(idx_r) * CHUNK_W +: CHUNK_W];
  assign chunk_b_s = shadow_b_r[int'(idx_r) * CHUNK_W +: CHUNK_W];

  icb_adder_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk (
    .a    (chunk_a_s),
    .b    (chunk_b_s),
    .cin  (carry_r),
    .s    (chunk_sum_s),
    .cout (chunk_cout_s)
  );

  // Merge the freshly computed chunk into the partial result
  always_comb begin
    full_result_s = result_r;
    full_result_s[int'(idx_r) * CHUNK_W +: CHUNK_W] = chunk_sum_s;
  end

  // Final value written to sum: wrap, or clamp to all ones on overflow
  always_comb begin
`ifdef ADDER_SAT_EN
    if (chunk_cout_s) begin
      sum_next_s = {DATA_W{1'b1}};
    end else begin
      sum_next_s = full_result_s;
    end
`else
    sum_next_s = full_result_s;
`endif
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sequencer next-state: IDLE until a start, ADD until the last chunk
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_ADD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (last_chunk_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ADD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-chunk accumulation and result/status update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_q_r <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      carry_r     <= 1'b0;
      shadow_a_r  <= {DATA_W{1'b0}};
      shadow_b_r  <= {DATA_W{1'b0}};
      result_r    <= {DATA_W{1'b0}};
      sum_r       <= {DATA_W{1'b0}};
      carry_out_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      control_q_r <= control;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            shadow_a_r <= augend;
            shadow_b_r <= addend;
            carry_r    <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            result_r   <= {DATA_W{1'b0}};
            busy_r     <= 1'b1;
          end
        end
        ST_ADD: begin
          result_r <= full_result_s;
          carry_r  <= chunk_cout_s;
          if (last_chunk_s) begin
            sum_r       <= sum_next_s;
            carry_out_r <= chunk_cout_s;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_icb_adder_core.sv
// Directed self-checking bench for icb_adder_core (default 32/8 geometry).
module tb_icb_adder_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] augend;
  logic [31:0] addend;
  logic        control;
  logic [31:0] sum;
  logic        carry_out;
  logic        busy;
  logic        done;

  int total;
  int bad;
  int done_cnt;

  icb_adder_core #(
    .DATA_W  (32),
    .CHUNK_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .augend    (augend),
    .addend    (addend),
    .control   (control),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, one sample per cycle on the falling edge
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Wait for done after the start edge; cyc counts edges from the request
  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // One complete addition: raise control, wait for done, drop control
  task automatic do_add(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_sum, input logic exp_co);
    int lat;
    int d0;
    @(negedge clk);
    augend  = a;
    addend  = b;
    control = 1'b1;
    d0 = done_cnt;
    wait_done(20, lat);
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_co"}, {31'd0, carry_out}, {31'd0, exp_co});
    @(negedge clk);
    control = 1'b0;
    @(negedge clk);
    check({tag, "_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int lat;
    logic [31:0] exp_wrap_sum;
    logic [31:0] exp_mid_sum;
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    control  = 1'b0;
    augend   = 32'd0;
    addend   = 32'd0;

`ifdef ADDER_SAT_EN
    exp_wrap_sum = 32'hFFFF_FFFF;
    exp_mid_sum  = 32'hFFFF_FFFF;
`else
    exp_wrap_sum = 32'h0000_0000;
    exp_mid_sum  = 32'h0000_0002;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sum", sum, 32'd0);
    check("rst_co", {31'd0, carry_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1 + 2 with cycle-by-cycle busy/done checks
    augend  = 32'h0000_0001;
    addend  = 32'h0000_0002;
    control = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    check("t1_busy_k", {31'd0, busy}, 32'd1);
    check("t1_done_k", {31'd0, done}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("t1_busy_mid", {31'd0, busy}, 32'd1);
      check("t1_done_mid", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    check("t1_done_k4", {31'd0, done}, 32'd1);
    check("t1_busy_k4", {31'd0, busy}, 32'd0);
    check("t1_sum", sum, 32'h0000_0003);
    check("t1_co", {31'd0, carry_out}, 32'd0);
    @(posedge clk); #1;
    check("t1_done_k5", {31'd0, done}, 32'd0);
    check("t1_sum_hold", sum, 32'h0000_0003);
    @(negedge clk);
    control = 1'b0;
    @(negedge clk);
    check("t1_pulses", 32'(done_cnt - d0), 32'd1);

    // Carry across chunk boundaries and full overflow
    do_add("t2", 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0);
    do_add("t3", 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
    do_add("t4", 32'hFFFF_FFFF, 32'h0000_0001, exp_wrap_sum, 1'b1);
    do_add("t5", 32'h8000_0001, 32'h8000_0001, exp_mid_sum, 1'b1);

    // Reset in the middle of an operation
    @(negedge clk);
    augend  = 32'h0000_0005;
    addend  = 32'h0000_0006;
    control = 1'b1;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    control = 1'b0;
    #1;
    check("rst_mid_sum", sum, 32'd0);
    check("rst_mid_co", {31'd0, carry_out}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_pulses", 32'(done_cnt - d0), 32'd0);
    check("rst_mid_sum_after", sum, 32'd0);
    do_add("t6", 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 1'b0);

    // Operand change and control re-toggle during busy are ignored
    @(negedge clk);
    augend  = 32'h0000_0010;
    addend  = 32'h0000_0020;
    control = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    augend  = 32'h0000_0099;
    control = 1'b0;
    @(negedge clk);
    control = 1'b1;
    @(negedge clk);
    control = 1'b0;
    wait_done(20, lat);
    check("t7_found_done", {31'd0, done}, 32'd1);
    repeat (10) @(negedge clk);
    check("t7_sum", sum, 32'h0000_0030);
    check("t7_pulses", 32'(done_cnt - d0), 32'd1);
    check("t7_busy", {31'd0, busy}, 32'd0);

    // control held high for 20 cycles starts exactly one operation
    @(negedge clk);
    augend  = 32'h0000_0005;
    addend  = 32'h0000_0007;
    control = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    control = 1'b0;
    repeat (3) @(negedge clk);
    check("t8_sum", sum, 32'h0000_000C);
    check("t8_pulses", 32'(done_cnt - d0), 32'd1);
    check("t8_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
